// File: rtl/pipelined_control_unit_pkg.sv
// Shared types for the pipelined control unit and its bus interface.
package pipelined_control_unit_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } aluop_t;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Bus between the pipelined control unit (master) and the datapath (slave).
interface pipelined_control_unit_if #(
  parameter int unsigned WORD_W = 32
);
  import pipelined_control_unit_pkg::*;

  // IF/ID and datapath status
  logic [WORD_W-1:0] instr;
  logic              instr_valid;
  logic              ihit;
  logic              dhit;
  logic              alu_zf;

  // Fetch control
  logic              pc_en;
  logic [2:0]        pcsrc;
  logic              ifid_en;
  logic              ifid_flush;

  // EX stage controls
  aluop_t            ex_aluop;
  logic              ex_alusrc;
  logic              ex_shamtsel;
  logic              ex_extop;
  logic              ex_regdst;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [4:0]        ex_shamt;
  logic [15:0]       ex_imm;

  // MEM / WB stage controls
  logic              mem_dren;
  logic              mem_dwen;
  logic              wb_regwr;
  logic              wb_memtoreg;
  logic [4:0]        wb_wsel;
  logic              halt;

  modport master (
    input  instr, instr_valid, ihit, dhit, alu_zf,
    output pc_en, pcsrc, ifid_en, ifid_flush,
    output ex_aluop, ex_alusrc, ex_shamtsel, ex_extop, ex_regdst,
    output ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm,
    output mem_dren, mem_dwen, wb_regwr, wb_memtoreg, wb_wsel, halt
  );

  modport slave (
    output instr, instr_valid, ihit, dhit, alu_zf,
    input  pc_en, pcsrc, ifid_en, ifid_flush,
    input  ex_aluop, ex_alusrc, ex_shamtsel, ex_extop, ex_regdst,
    input  ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm,
    input  mem_dren, mem_dwen, wb_regwr, wb_memtoreg, wb_wsel, halt
  );

endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: decodes IF/ID, carries control records through
// ID/EX, EX/MEM and MEM/WB, and generates stall/flush/redirect for fetch.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter bit          HAZARD_EN  = 1'b1,
  parameter bit          JUMP_IN_ID = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  pipelined_control_unit_if.master  bus
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpHalt  = 6'h3f;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // Control record carried down the pipe; all-zero is a bubble.
  typedef struct packed {
    logic       valid;
    aluop_t     aluop;
    logic       alusrc;
    logic       shamtsel;
    logic       extop;
    logic       regdst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [15:0] imm;
    logic       dren;
    logic       dwen;
    logic       regwr;
    logic       memtoreg;
    logic [4:0] wsel;
    logic       reads_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_jr;
    logic       is_j;
    logic       is_halt;
  } ctrl_t;

  logic [WORD_W-1:0] instr_w;
  logic [31:0]       ir;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  ctrl_t             dec;

  ctrl_t idex_q, idex_d;
  ctrl_t exmem_q, exmem_d;
  ctrl_t memwb_q, memwb_d;
  logic  halt_q;

  logic       halt_now;
  logic       mem_wait;
  logic       br_taken;
  logic       jr_ex;
  logic       j_ex;
  logic       load_use;
  logic       j_id;
  logic       pc_en;
  logic [2:0] pcsrc;
  logic       ifid_en;
  logic       ifid_flush;

  assign instr_w = bus.instr;
  assign ir      = instr_w[31:0];
  assign opcode  = ir[31:26];
  assign funct   = ir[5:0];

  // Decode the IF/ID instruction into a control record; unknown encodings give a bubble.
  always_comb begin
    dec = '0;
    if (bus.instr_valid) begin
      case (opcode)
        OpRtype: begin
          dec.valid    = 1'b1;
          dec.regdst   = 1'b1;
          dec.regwr    = 1'b1;
          dec.wsel     = ir[15:11];
          dec.reads_rt = 1'b1;
          case (funct)
            FnSll:  begin dec.aluop = ALU_SLL; dec.shamtsel = 1'b1; end
            FnSrl:  begin dec.aluop = ALU_SRL; dec.shamtsel = 1'b1; end
            FnAdd, FnAddu: dec.aluop = ALU_ADD;
            FnSub, FnSubu: dec.aluop = ALU_SUB;
            FnAnd:  dec.aluop = ALU_AND;
            FnOr:   dec.aluop = ALU_OR;
            FnXor:  dec.aluop = ALU_XOR;
            FnNor:  dec.aluop = ALU_NOR;
            FnSlt:  dec.aluop = ALU_SLT;
            FnSltu: dec.aluop = ALU_SLTU;
            FnJr: begin
              dec.is_jr  = 1'b1;
              dec.regdst = 1'b0;
              dec.regwr  = 1'b0;
              dec.wsel   = 5'd0;
            end
            default: dec = '0;
          endcase
        end
        OpAddi, OpAddiu, OpSlti, OpSltiu: begin
          dec.valid  = 1'b1;
          dec.aluop  = (opcode == OpSlti)  ? ALU_SLT  :
                       (opcode == OpSltiu) ? ALU_SLTU : ALU_ADD;
          dec.alusrc = 1'b1;
          dec.extop  = 1'b1;
          dec.regwr  = 1'b1;
          dec.wsel   = ir[20:16];
        end
        OpAndi, OpOri, OpXori, OpLui: begin
          dec.valid  = 1'b1;
          dec.aluop  = (opcode == OpAndi) ? ALU_AND :
                       (opcode == OpOri)  ? ALU_OR  :
                       (opcode == OpXori) ? ALU_XOR : ALU_LUI;
          dec.alusrc = 1'b1;
          dec.regwr  = 1'b1;
          dec.wsel   = ir[20:16];
        end
        OpLw: begin
          dec.valid    = 1'b1;
          dec.aluop    = ALU_ADD;
          dec.alusrc   = 1'b1;
          dec.extop    = 1'b1;
          dec.dren     = 1'b1;
          dec.regwr    = 1'b1;
          dec.memtoreg = 1'b1;
          dec.wsel     = ir[20:16];
        end
        OpSw: begin
          dec.valid    = 1'b1;
          dec.aluop    = ALU_ADD;
          dec.alusrc   = 1'b1;
          dec.extop    = 1'b1;
          dec.dwen     = 1'b1;
          dec.reads_rt = 1'b1;
        end
        OpBeq, OpBne: begin
          dec.valid    = 1'b1;
          dec.aluop    = ALU_SUB;
          dec.extop    = 1'b1;
          dec.reads_rt = 1'b1;
          dec.is_beq   = (opcode == OpBeq);
          dec.is_bne   = (opcode == OpBne);
        end
        OpJ: begin
          dec.valid = 1'b1;
          dec.is_j  = 1'b1;
        end
        OpJal: begin
          // Link register is selected by the WB destination, not by regdst.
          dec.valid = 1'b1;
          dec.is_j  = 1'b1;
          dec.regwr = 1'b1;
          dec.wsel  = 5'd31;
        end
        OpHalt: begin
          dec.valid   = 1'b1;
          dec.is_halt = 1'b1;
        end
        default: dec = '0;
      endcase
      if (dec.valid) begin
        dec.rs    = ir[25:21];
        dec.rt    = ir[20:16];
        dec.rd    = ir[15:11];
        dec.shamt = ir[10:6];
        dec.imm   = ir[15:0];
      end
    end
  end

  assign halt_now = halt_q | (memwb_q.valid & memwb_q.is_halt);
  assign mem_wait = exmem_q.valid & (exmem_q.dren | exmem_q.dwen) & ~bus.dhit;
  assign br_taken = idex_q.valid &
                    ((idex_q.is_beq & bus.alu_zf) | (idex_q.is_bne & ~bus.alu_zf));
  assign jr_ex    = idex_q.valid & idex_q.is_jr;
  assign j_ex     = idex_q.valid & idex_q.is_j & ~JUMP_IN_ID;
  assign load_use = HAZARD_EN & idex_q.valid & idex_q.dren & (idex_q.rt != 5'd0) & dec.valid &
                    ((idex_q.rt == dec.rs) | (dec.reads_rt & (idex_q.rt == dec.rt)));
  assign j_id     = JUMP_IN_ID & dec.valid & dec.is_j;

  // Prioritised stall/flush/redirect and next-state of the stage registers.
  always_comb begin
    pc_en      = 1'b0;
    pcsrc      = 3'd0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_d     = idex_q;
    exmem_d    = exmem_q;
    memwb_d    = memwb_q;
    if (rst) begin
      ifid_flush = 1'b1;
    end else if (halt_now) begin
      // Drain everything behind the HALT so nothing further writes.
      idex_d  = '0;
      exmem_d = '0;
      memwb_d = '0;
    end else if (mem_wait) begin
      // Freeze: registers hold, fetch and any pending redirect wait for dhit.
    end else if (br_taken | jr_ex | j_ex) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      pcsrc      = br_taken ? 3'd1 : (jr_ex ? 3'd3 : 3'd2);
      idex_d     = '0;
      exmem_d    = idex_q;
      memwb_d    = exmem_q;
    end else if (load_use) begin
      idex_d  = '0;
      exmem_d = idex_q;
      memwb_d = exmem_q;
    end else begin
      ifid_en = 1'b1;
      idex_d  = dec;
      exmem_d = idex_q;
      memwb_d = exmem_q;
      if (j_id) begin
        pcsrc      = 3'd2;
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
      end else if (!bus.ihit) begin
        ifid_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  // Stage control registers, reset to bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Sticky halt, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (memwb_q.valid && memwb_q.is_halt) begin
      halt_q <= 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.pcsrc       = pcsrc;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.ex_aluop    = idex_q.aluop;
  assign bus.ex_alusrc   = idex_q.alusrc;
  assign bus.ex_shamtsel = idex_q.shamtsel;
  assign bus.ex_extop    = idex_q.extop;
  assign bus.ex_regdst   = idex_q.regdst;
  assign bus.ex_rs       = idex_q.rs;
  assign bus.ex_rt       = idex_q.rt;
  assign bus.ex_rd       = idex_q.rd;
  assign bus.ex_shamt    = idex_q.shamt;
  assign bus.ex_imm      = idex_q.imm;
  assign bus.mem_dren    = exmem_q.dren & ~halt_now;
  assign bus.mem_dwen    = exmem_q.dwen & ~halt_now;
  assign bus.wb_regwr    = memwb_q.regwr & ~halt_now;
  assign bus.wb_memtoreg = memwb_q.memtoreg;
  assign bus.wb_wsel     = memwb_q.wsel;
  assign bus.halt        = halt_now;

  // Record bits that only matter in earlier stages are carried but not read at WB.
  logic unused_wb;
  assign unused_wb = ^memwb_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: dut_a (interlock on, jumps in ID) and dut_b (no interlock,
// jumps in EX) share one stimulus stream.
module tb_pipelined_control_unit;
  import pipelined_control_unit_pkg::*;

  localparam logic [31:0] I_ADDU3  = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] I_ADDU4  = 32'h0043_2021; // addu $4,$2,$3
  localparam logic [31:0] I_ADDIU5 = 32'h2405_ffff; // addiu $5,$0,-1
  localparam logic [31:0] I_ORI6   = 32'h3406_00f0; // ori $6,$0,0xf0
  localparam logic [31:0] I_LW2    = 32'h8c22_0000; // lw $2,0($1)
  localparam logic [31:0] I_LW7    = 32'h8c27_0000; // lw $7,0($1)
  localparam logic [31:0] I_SW     = 32'hac22_0008; // sw $2,8($1)
  localparam logic [31:0] I_BEQ    = 32'h1022_0004; // beq $1,$2,4
  localparam logic [31:0] I_JR31   = 32'h03e0_0008; // jr $31
  localparam logic [31:0] I_JAL    = 32'h0c00_0100; // jal 0x100
  localparam logic [31:0] I_HALT   = 32'hfc00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        ihit = 1'b1;
  logic        dhit = 1'b1;
  logic        alu_zf = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.WORD_W(32)) bus_a ();
  pipelined_control_unit_if #(.WORD_W(32)) bus_b ();

  assign bus_a.instr = instr;
  assign bus_a.instr_valid = instr_valid;
  assign bus_a.ihit = ihit;
  assign bus_a.dhit = dhit;
  assign bus_a.alu_zf = alu_zf;
  assign bus_b.instr = instr;
  assign bus_b.instr_valid = instr_valid;
  assign bus_b.ihit = ihit;
  assign bus_b.dhit = dhit;
  assign bus_b.alu_zf = alu_zf;

  pipelined_control_unit #(.WORD_W(32), .HAZARD_EN(1'b1), .JUMP_IN_ID(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipelined_control_unit #(.WORD_W(32), .HAZARD_EN(1'b0), .JUMP_IN_ID(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Advance one clock and present the next cycle's inputs; outputs settle 1ns later.
  task automatic cyc(input logic [31:0] i, input logic v, input logic ih, input logic dh,
                     input logic zf);
    @(posedge clk);
    #1;
    instr = i; instr_valid = v; ihit = ih; dhit = dh; alu_zf = zf;
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1; instr = '0; instr_valid = 1'b0; ihit = 1'b1; dhit = 1'b1; alu_zf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    #1 instr = I_ADDU3; instr_valid = 1'b1; ihit = 1'b1;
    #1;
    checks++; if (bus_a.pc_en !== 1'b0) begin failures++;
      $display("FAIL rst_pc_en got=%0d exp=0", bus_a.pc_en); end
    checks++; if (bus_a.ifid_en !== 1'b0) begin failures++;
      $display("FAIL rst_ifid_en got=%0d exp=0", bus_a.ifid_en); end
    checks++; if (bus_a.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL rst_ifid_flush got=%0d exp=1", bus_a.ifid_flush); end
    checks++; if (bus_a.pcsrc !== 3'd0) begin failures++;
      $display("FAIL rst_pcsrc got=%0d exp=0", bus_a.pcsrc); end
    checks++; if (bus_a.ex_rd !== 5'd0 || bus_a.ex_aluop !== ALU_SLL) begin failures++;
      $display("FAIL rst_ex got=%0d/%0d exp=0/0", bus_a.ex_rd, bus_a.ex_aluop); end
    checks++; if (bus_a.wb_regwr !== 1'b0 || bus_a.mem_dren !== 1'b0) begin failures++;
      $display("FAIL rst_wb_mem got=%0d/%0d exp=0/0", bus_a.wb_regwr, bus_a.mem_dren); end
    checks++; if (bus_a.halt !== 1'b0) begin failures++;
      $display("FAIL rst_halt got=%0d exp=0", bus_a.halt); end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.pc_en !== 1'b1 || bus_a.ifid_en !== 1'b1) begin failures++;
      $display("FAIL rst_release got=%0d/%0d exp=1/1", bus_a.pc_en, bus_a.ifid_en); end
  endtask

  task automatic test_alu;
    reset_dut();
    cyc(I_ADDU3, 1, 1, 1, 0);
    checks++; if (bus_a.pc_en !== 1'b1 || bus_a.pcsrc !== 3'd0) begin failures++;
      $display("FAIL alu_fetch got=%0d/%0d exp=1/0", bus_a.pc_en, bus_a.pcsrc); end
    cyc(I_ADDIU5, 1, 1, 1, 0);
    checks++; if (bus_a.ex_aluop !== ALU_ADD) begin failures++;
      $display("FAIL addu_aluop got=%0d exp=%0d", bus_a.ex_aluop, ALU_ADD); end
    checks++; if ({bus_a.ex_rs, bus_a.ex_rt, bus_a.ex_rd} !== {5'd1, 5'd2, 5'd3}) begin
      failures++;
      $display("FAIL addu_regs got=%0d,%0d,%0d exp=1,2,3", bus_a.ex_rs, bus_a.ex_rt,
               bus_a.ex_rd); end
    checks++; if (bus_a.ex_regdst !== 1'b1 || bus_a.ex_alusrc !== 1'b0) begin failures++;
      $display("FAIL addu_mux got=%0d/%0d exp=1/0", bus_a.ex_regdst, bus_a.ex_alusrc); end
    cyc(I_ORI6, 1, 1, 1, 0);
    checks++; if (bus_a.ex_alusrc !== 1'b1 || bus_a.ex_extop !== 1'b1) begin failures++;
      $display("FAIL addiu_mux got=%0d/%0d exp=1/1", bus_a.ex_alusrc, bus_a.ex_extop); end
    checks++; if (bus_a.ex_imm !== 16'hffff || bus_a.ex_regdst !== 1'b0) begin failures++;
      $display("FAIL addiu_imm got=%h/%0d exp=ffff/0", bus_a.ex_imm, bus_a.ex_regdst); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.ex_aluop !== ALU_OR || bus_a.ex_extop !== 1'b0) begin failures++;
      $display("FAIL ori_ctl got=%0d/%0d exp=%0d/0", bus_a.ex_aluop, bus_a.ex_extop, ALU_OR);
    end
    checks++; if (bus_a.wb_regwr !== 1'b1 || bus_a.wb_wsel !== 5'd3) begin failures++;
      $display("FAIL addu_wb got=%0d/%0d exp=1/3", bus_a.wb_regwr, bus_a.wb_wsel); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.wb_wsel !== 5'd5 || bus_a.wb_memtoreg !== 1'b0) begin failures++;
      $display("FAIL addiu_wb got=%0d/%0d exp=5/0", bus_a.wb_wsel, bus_a.wb_memtoreg); end
    cyc(I_ADDU3, 1, 0, 1, 0);
    checks++; if ({bus_a.pc_en, bus_a.ifid_en, bus_a.ifid_flush} !== 3'b011) begin
      failures++;
      $display("FAIL imiss got=%b exp=011", {bus_a.pc_en, bus_a.ifid_en, bus_a.ifid_flush});
    end
  endtask

  task automatic test_load_use;
    reset_dut();
    cyc(I_LW2, 1, 1, 1, 0);
    cyc(I_ADDU4, 1, 1, 1, 0);
    checks++; if (bus_a.pc_en !== 1'b0 || bus_a.ifid_en !== 1'b0) begin failures++;
      $display("FAIL lu_stall got=%0d/%0d exp=0/0", bus_a.pc_en, bus_a.ifid_en); end
    checks++; if (bus_b.pc_en !== 1'b1 || bus_b.ifid_en !== 1'b1) begin failures++;
      $display("FAIL lu_nohaz got=%0d/%0d exp=1/1", bus_b.pc_en, bus_b.ifid_en); end
    cyc(I_ADDU4, 1, 1, 1, 0);
    checks++; if (bus_a.ex_rd !== 5'd0 || bus_a.ex_aluop !== ALU_SLL) begin failures++;
      $display("FAIL lu_bubble got=%0d/%0d exp=0/0", bus_a.ex_rd, bus_a.ex_aluop); end
    checks++; if (bus_a.mem_dren !== 1'b1 || bus_a.pc_en !== 1'b1) begin failures++;
      $display("FAIL lu_advance got=%0d/%0d exp=1/1", bus_a.mem_dren, bus_a.pc_en); end
    checks++; if (bus_b.ex_rd !== 5'd4) begin failures++;
      $display("FAIL lu_nohaz_ex got=%0d exp=4", bus_b.ex_rd); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.ex_rd !== 5'd4) begin failures++;
      $display("FAIL lu_resume got=%0d exp=4", bus_a.ex_rd); end
    checks++; if ({bus_a.wb_regwr, bus_a.wb_memtoreg, bus_a.wb_wsel} !== {2'b11, 5'd2}) begin
      failures++;
      $display("FAIL lw_wb got=%0d/%0d/%0d exp=1/1/2", bus_a.wb_regwr, bus_a.wb_memtoreg,
               bus_a.wb_wsel); end
  endtask

  task automatic test_branch;
    reset_dut();
    cyc(I_BEQ, 1, 1, 1, 0);
    cyc(I_ADDU3, 1, 1, 1, 1);
    checks++; if (bus_a.pcsrc !== 3'd1 || bus_a.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL beq_taken got=%0d/%0d exp=1/1", bus_a.pcsrc, bus_a.ifid_flush); end
    checks++; if (bus_a.pc_en !== 1'b1 || bus_b.pcsrc !== 3'd1) begin failures++;
      $display("FAIL beq_pc got=%0d/%0d exp=1/1", bus_a.pc_en, bus_b.pcsrc); end
    cyc(I_BEQ, 1, 1, 1, 0);
    checks++; if ({bus_a.ex_rs, bus_a.ex_rd, bus_a.ex_imm} !== '0 ||
                  bus_a.ex_aluop !== ALU_SLL) begin failures++;
      $display("FAIL beq_flush_ex got=%0d/%0d/%h/%0d exp=0/0/0/0", bus_a.ex_rs, bus_a.ex_rd,
               bus_a.ex_imm, bus_a.ex_aluop); end
    cyc(I_ADDU3, 1, 1, 1, 0);
    checks++; if (bus_a.pcsrc !== 3'd0 || bus_a.ifid_flush !== 1'b0) begin failures++;
      $display("FAIL beq_not_taken got=%0d/%0d exp=0/0", bus_a.pcsrc, bus_a.ifid_flush); end
    cyc(I_JR31, 1, 1, 1, 0);
    checks++; if (bus_a.ex_rd !== 5'd3) begin failures++;
      $display("FAIL beq_nt_follow got=%0d exp=3", bus_a.ex_rd); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.pcsrc !== 3'd3 || bus_a.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL jr_ex got=%0d/%0d exp=3/1", bus_a.pcsrc, bus_a.ifid_flush); end
  endtask

  task automatic test_mem_wait;
    reset_dut();
    cyc(I_SW, 1, 1, 1, 0);
    cyc(I_ADDU3, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc('0, 0, 1, 0, 0);
      checks++; if (bus_a.pc_en !== 1'b0 || bus_a.ifid_en !== 1'b0) begin failures++;
        $display("FAIL mw_stall%0d got=%0d/%0d exp=0/0", k, bus_a.pc_en, bus_a.ifid_en); end
      checks++; if (bus_a.mem_dwen !== 1'b1 || bus_a.ex_rd !== 5'd3) begin failures++;
        $display("FAIL mw_frozen%0d got=%0d/%0d exp=1/3", k, bus_a.mem_dwen, bus_a.ex_rd); end
    end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.mem_dwen !== 1'b1 || bus_a.pc_en !== 1'b1) begin failures++;
      $display("FAIL mw_release got=%0d/%0d exp=1/1", bus_a.mem_dwen, bus_a.pc_en); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.mem_dwen !== 1'b0 || bus_a.ex_rd !== 5'd0) begin failures++;
      $display("FAIL mw_advance got=%0d/%0d exp=0/0", bus_a.mem_dwen, bus_a.ex_rd); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.wb_regwr !== 1'b1 || bus_a.wb_wsel !== 5'd3) begin failures++;
      $display("FAIL mw_wb got=%0d/%0d exp=1/3", bus_a.wb_regwr, bus_a.wb_wsel); end
    // Memory wait holds off a taken branch until dhit.
    reset_dut();
    cyc(I_LW7, 1, 1, 1, 0);
    cyc(I_BEQ, 1, 1, 1, 0);
    cyc('0, 0, 1, 0, 1);
    checks++; if (bus_a.pc_en !== 1'b0 || bus_a.ifid_flush !== 1'b0) begin failures++;
      $display("FAIL mw_br_hold got=%0d/%0d exp=0/0", bus_a.pc_en, bus_a.ifid_flush); end
    cyc('0, 0, 1, 1, 1);
    checks++; if (bus_a.pcsrc !== 3'd1 || bus_a.pc_en !== 1'b1) begin failures++;
      $display("FAIL mw_br_take got=%0d/%0d exp=1/1", bus_a.pcsrc, bus_a.pc_en); end
  endtask

  task automatic test_jal;
    reset_dut();
    cyc(I_JAL, 1, 1, 1, 0);
    checks++; if (bus_a.pcsrc !== 3'd2 || bus_a.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL jal_id got=%0d/%0d exp=2/1", bus_a.pcsrc, bus_a.ifid_flush); end
    checks++; if (bus_b.pcsrc !== 3'd0 || bus_b.ifid_flush !== 1'b0) begin failures++;
      $display("FAIL jal_id_b got=%0d/%0d exp=0/0", bus_b.pcsrc, bus_b.ifid_flush); end
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.pcsrc !== 3'd0 || bus_a.pc_en !== 1'b1) begin failures++;
      $display("FAIL jal_after got=%0d/%0d exp=0/1", bus_a.pcsrc, bus_a.pc_en); end
    checks++; if (bus_b.pcsrc !== 3'd2 || bus_b.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL jal_ex_b got=%0d/%0d exp=2/1", bus_b.pcsrc, bus_b.ifid_flush); end
    cyc('0, 0, 1, 1, 0);
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.wb_regwr !== 1'b1 || bus_a.wb_wsel !== 5'd31) begin failures++;
      $display("FAIL jal_wb got=%0d/%0d exp=1/31", bus_a.wb_regwr, bus_a.wb_wsel); end
    checks++; if (bus_b.wb_wsel !== 5'd31) begin failures++;
      $display("FAIL jal_wb_b got=%0d exp=31", bus_b.wb_wsel); end
  endtask

  task automatic test_halt;
    reset_dut();
    cyc(I_HALT, 1, 1, 1, 0);
    cyc('0, 0, 1, 1, 0);
    cyc('0, 0, 1, 1, 0);
    checks++; if (bus_a.halt !== 1'b0) begin failures++;
      $display("FAIL halt_early got=%0d exp=0", bus_a.halt); end
    cyc(I_ADDU3, 1, 1, 1, 0);
    checks++; if (bus_a.halt !== 1'b1 || bus_a.pc_en !== 1'b0 || bus_a.ifid_en !== 1'b0) begin
      failures++;
      $display("FAIL halt_set got=%0d/%0d/%0d exp=1/0/0", bus_a.halt, bus_a.pc_en,
               bus_a.ifid_en); end
    for (int k = 0; k < 3; k++) begin
      cyc(I_ADDU3, 1, 1, 1, 0);
      checks++; if (bus_a.halt !== 1'b1 || bus_a.pc_en !== 1'b0) begin failures++;
        $display("FAIL halt_sticky%0d got=%0d/%0d exp=1/0", k, bus_a.halt, bus_a.pc_en); end
      checks++; if (bus_a.wb_regwr !== 1'b0 || bus_a.ex_rd !== 5'd0) begin failures++;
        $display("FAIL halt_quiet%0d got=%0d/%0d exp=0/0", k, bus_a.wb_regwr, bus_a.ex_rd); end
    end
    rst = 1'b1;
    #1;
    checks++; if (bus_a.halt !== 1'b0 || bus_a.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL halt_rst got=%0d/%0d exp=0/1", bus_a.halt, bus_a.ifid_flush); end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.pc_en !== 1'b1 || bus_a.halt !== 1'b0) begin failures++;
      $display("FAIL halt_resume got=%0d/%0d exp=1/0", bus_a.pc_en, bus_a.halt); end
  endtask

  task automatic test_reset_mid_stall;
    reset_dut();
    cyc(I_LW2, 1, 1, 1, 0);
    cyc(I_ADDU4, 1, 1, 1, 0);
    rst = 1'b1;
    #1;
    checks++; if (bus_a.ex_rt !== 5'd0 || bus_a.ex_aluop !== ALU_SLL) begin failures++;
      $display("FAIL mid_rst_ex got=%0d/%0d exp=0/0", bus_a.ex_rt, bus_a.ex_aluop); end
    checks++; if (bus_a.pc_en !== 1'b0 || bus_a.ifid_flush !== 1'b1) begin failures++;
      $display("FAIL mid_rst_ctl got=%0d/%0d exp=0/1", bus_a.pc_en, bus_a.ifid_flush); end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.pc_en !== 1'b1 || bus_a.ifid_en !== 1'b1) begin failures++;
      $display("FAIL mid_rst_clear got=%0d/%0d exp=1/1", bus_a.pc_en, bus_a.ifid_en); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_jal();
    test_halt();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
